// File: rtl/memory_interface_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : memory_interface_unit
// Purpose  : Memory interface stage between the control unit and a req/ack
//            memory port. Owns MAR and MBR, converts MFA/READ_WRITE/WORD_BYTE
//            into one memory transaction, steers byte lanes and returns MFC.
//            A request timer aborts a transaction if memory never acknowledges,
//            so MFC is always returned (with BusErr = 1 on abort).
// Config   : MIU_ALIGN_CHECK_EN - when defined, a word access with
//            MAR[1:0] != 0 completes immediately with BusErr = 1 and no
//            memory request is issued.
// Ports    : Clk, Reset (async, active-high)
//            MARLOAD, MBRLOAD, MBRSTORE, DataIn[31:0], DataOut[31:0]
//            MFA, READ_WRITE, WORD_BYTE  -> MFC, BusErr
//            MemAddr, MemWData, MemBE, MemReq, MemWE -> memory
//            MemAck, MemRData <- memory
// Revision : 1.0 - initial release
// ============================================================================
module memory_interface_unit #(
  parameter int TIMEOUT = 16  // REQ cycles without MemAck before abort, 1..255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MARLOAD,
  input  logic        MBRLOAD,
  input  logic        MBRSTORE,
  input  logic        MFA,
  input  logic        READ_WRITE,
  input  logic        WORD_BYTE,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        BusErr,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  output logic        MemReq,
  output logic        MemWE,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);

  // Timer value on the last permitted REQ cycle.
  localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_mar;
  logic [31:0] r_mbr;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_mem_req;
  logic        r_mem_we;
  logic        r_mfc;
  logic        r_bus_err;
  logic        r_op_read;
  logic        r_op_word;
  logic [1:0]  r_lane;
  logic [7:0]  r_timer;

  logic [7:0]  w_rd_byte;
  logic [31:0] w_rd_data;
  logic        w_misaligned;

  // Read lane select uses the lane latched at launch, not the live MAR,
  // because MAR may have been reloaded in the launching cycle.
  always_comb begin
    w_rd_byte = 8'h00;
    case (r_lane)
      2'd0:    w_rd_byte = MemRData[7:0];
      2'd1:    w_rd_byte = MemRData[15:8];
      2'd2:    w_rd_byte = MemRData[23:16];
      default: w_rd_byte = MemRData[31:24];
    endcase
    w_rd_data = r_op_word ? MemRData : {24'h0, w_rd_byte};
  end

`ifdef MIU_ALIGN_CHECK_EN
  assign w_misaligned = WORD_BYTE && (r_mar[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_mar       <= 32'h0;
      r_mbr       <= 32'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= 4'h0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mfc       <= 1'b0;
      r_bus_err   <= 1'b0;
      r_op_read   <= 1'b0;
      r_op_word   <= 1'b0;
      r_lane      <= 2'd0;
      r_timer     <= 8'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MARLOAD) r_mar <= DataIn;
          if (MBRLOAD) r_mbr <= DataIn;
          if (MFA) begin
            // Everything the transaction needs is captured from the
            // pre-load MAR/MBR, so a simultaneous load does not affect it.
            r_op_read   <= READ_WRITE;
            r_op_word   <= WORD_BYTE;
            r_lane      <= r_mar[1:0];
            r_timer     <= 8'h0;
            r_mem_addr  <= {r_mar[31:2], 2'b00};
            r_mem_be    <= WORD_BYTE ? 4'hF : (4'b0001 << r_mar[1:0]);
            r_mem_wdata <= WORD_BYTE ? r_mbr : {4{r_mbr[7:0]}};
            if (w_misaligned) begin
              r_state   <= S_DONE;
              r_mfc     <= 1'b1;
              r_bus_err <= 1'b1;
            end else begin
              r_state   <= S_REQ;
              r_mem_req <= 1'b1;
              r_mem_we  <= ~READ_WRITE;
            end
          end
        end

        S_REQ: begin
          // Acknowledge takes priority over an expiring timer.
          if (MemAck) begin
            if (r_op_read) r_mbr <= w_rd_data;
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mfc     <= 1'b1;
            r_bus_err <= 1'b0;
          end else if (r_timer == c_TIMER_LAST) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mfc     <= 1'b1;
            r_bus_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        S_DONE: begin
          if (!MFA) begin
            r_state   <= S_IDLE;
            r_mfc     <= 1'b0;
            r_bus_err <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DataOut  = MBRSTORE ? r_mbr : 32'h0;
  assign MFC      = r_mfc;
  assign BusErr   = r_bus_err;
  assign MemAddr  = r_mem_addr;
  assign MemWData = r_mem_wdata;
  assign MemBE    = r_mem_be;
  assign MemReq   = r_mem_req;
  assign MemWE    = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_memory_interface_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_memory_interface_unit
// Purpose  : Directed self-checking bench for memory_interface_unit
//            (TIMEOUT = 4). Honours MIU_ALIGN_CHECK_EN for the unaligned case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_interface_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MARLOAD = 1'b0;
  logic        MBRLOAD = 1'b0;
  logic        MBRSTORE = 1'b0;
  logic        MFA = 1'b0;
  logic        READ_WRITE = 1'b0;
  logic        WORD_BYTE = 1'b0;
  logic [31:0] DataIn = 32'h0;
  logic [31:0] DataOut;
  logic        MFC;
  logic        BusErr;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBE;
  logic        MemReq;
  logic        MemWE;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = 32'h0;

  int checks = 0;
  int errors = 0;

  memory_interface_unit #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .MARLOAD(MARLOAD), .MBRLOAD(MBRLOAD),
    .MBRSTORE(MBRSTORE), .MFA(MFA), .READ_WRITE(READ_WRITE),
    .WORD_BYTE(WORD_BYTE), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC),
    .BusErr(BusErr), .MemAddr(MemAddr), .MemWData(MemWData), .MemBE(MemBE),
    .MemReq(MemReq), .MemWE(MemWE), .MemAck(MemAck), .MemRData(MemRData)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_mar(input logic [31:0] v);
    MARLOAD = 1'b1; DataIn = v;
    tick();
    MARLOAD = 1'b0;
  endtask

  task automatic load_mbr(input logic [31:0] v);
    MBRLOAD = 1'b1; DataIn = v;
    tick();
    MBRLOAD = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst_memreq", {31'h0, MemReq}, 32'h0);
    chk("rst_mfc",    {31'h0, MFC},    32'h0);
    chk("rst_buserr", {31'h0, BusErr}, 32'h0);
    chk("rst_addr",   MemAddr,         32'h0);
    chk("rst_be",     {28'h0, MemBE},  32'h0);
    chk("rst_we",     {31'h0, MemWE},  32'h0);
    tick(); tick();
    Reset = 1'b0;
    MBRSTORE = 1'b1;
    chk("rst_mbr", DataOut, 32'h0);

    // ---------------- word read, zero wait ----------------
    load_mar(32'h100);
    MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b1; MemRData = 32'hDEADBEEF;
    tick();                                   // edge 0
    chk("wr0_memreq", {31'h0, MemReq}, 32'h1);
    chk("wr0_addr",   MemAddr,         32'h100);
    chk("wr0_be",     {28'h0, MemBE},  32'hF);
    chk("wr0_we",     {31'h0, MemWE},  32'h0);
    chk("wr0_mfc",    {31'h0, MFC},    32'h0);
    MemAck = 1'b1;
    tick();                                   // edge 1
    MemAck = 1'b0;
    chk("wr1_mfc",    {31'h0, MFC},    32'h1);
    chk("wr1_buserr", {31'h0, BusErr}, 32'h0);
    chk("wr1_memreq", {31'h0, MemReq}, 32'h0);
    chk("wr1_mbr",    DataOut,         32'hDEADBEEF);
    tick();                                   // MFA still high: hold DONE
    chk("wr_hold_mfc", {31'h0, MFC}, 32'h1);
    MFA = 1'b0;
    tick();
    chk("wr_idle_mfc", {31'h0, MFC}, 32'h0);

    // ---------------- byte write, 3 wait cycles ----------------
    load_mar(32'h203);
    load_mbr(32'h000000A5);
    MFA = 1'b1; READ_WRITE = 1'b0; WORD_BYTE = 1'b0;
    tick();                                   // edge 0
    chk("bw_memreq", {31'h0, MemReq}, 32'h1);
    chk("bw_addr",   MemAddr,         32'h200);
    chk("bw_be",     {28'h0, MemBE},  32'h8);
    chk("bw_wdata",  MemWData,        32'hA5A5A5A5);
    chk("bw_we",     {31'h0, MemWE},  32'h1);
    tick(); tick(); tick();                   // edges 1..3, no ack
    chk("bw_wait_mfc",    {31'h0, MFC},    32'h0);
    chk("bw_wait_memreq", {31'h0, MemReq}, 32'h1);
    MemAck = 1'b1;
    tick();                                   // edge 4
    MemAck = 1'b0;
    chk("bw_mfc",    {31'h0, MFC},    32'h1);
    chk("bw_buserr", {31'h0, BusErr}, 32'h0);
    chk("bw_mbr",    DataOut,         32'h000000A5);
    MFA = 1'b0;
    tick();

    // ---------------- byte read, MAR reloaded on the launch cycle ----------------
    load_mar(32'h11);
    MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b0; MemRData = 32'h44332211;
    MARLOAD = 1'b1; DataIn = 32'h300;
    tick();                                   // edge 0
    MARLOAD = 1'b0;
    chk("br_addr", MemAddr,        32'h10);
    chk("br_be",   {28'h0, MemBE}, 32'h2);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    chk("br_mfc", {31'h0, MFC}, 32'h1);
    chk("br_mbr", DataOut,      32'h00000022);
    MFA = 1'b0;
    tick();

    // ---------------- timeout, no ack (MAR now 0x300) ----------------
    MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b1; MemRData = 32'hFFFFFFFF;
    tick();                                   // edge 0
    chk("to_addr", MemAddr, 32'h300);
    tick(); tick(); tick();                   // edges 1..3
    chk("to_req3", {31'h0, MemReq}, 32'h1);
    chk("to_mfc3", {31'h0, MFC},    32'h0);
    tick();                                   // edge 4: abort
    chk("to_req4",    {31'h0, MemReq}, 32'h0);
    chk("to_mfc4",    {31'h0, MFC},    32'h1);
    chk("to_buserr",  {31'h0, BusErr}, 32'h1);
    chk("to_mbr",     DataOut,         32'h00000022);
    MFA = 1'b0;
    tick();
    chk("to_idle_mfc",    {31'h0, MFC},    32'h0);
    chk("to_idle_buserr", {31'h0, BusErr}, 32'h0);

    // ---------------- ack on the expiry edge wins ----------------
    MFA = 1'b1; MemRData = 32'h12345678;
    tick();                                   // edge 0
    tick(); tick(); tick();                   // edges 1..3
    MemAck = 1'b1;
    tick();                                   // edge 4
    MemAck = 1'b0;
    chk("ae_mfc",    {31'h0, MFC},    32'h1);
    chk("ae_buserr", {31'h0, BusErr}, 32'h0);
    chk("ae_mbr",    DataOut,         32'h12345678);
    MFA = 1'b0;
    tick();

    // ---------------- stray ack in IDLE is ignored ----------------
    MemAck = 1'b1; MemRData = 32'hBAD0BAD0;
    tick();
    MemAck = 1'b0;
    chk("ia_memreq", {31'h0, MemReq}, 32'h0);
    chk("ia_mfc",    {31'h0, MFC},    32'h0);
    chk("ia_mbr",    DataOut,         32'h12345678);
    MBRSTORE = 1'b0;
    #1;
    chk("nostore_dataout", DataOut, 32'h0);
    MBRSTORE = 1'b1;

    // ---------------- reset mid-REQ ----------------
    MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b1;
    tick();
    chk("rm_memreq_pre", {31'h0, MemReq}, 32'h1);
    Reset = 1'b1; MFA = 1'b0;
    #1;
    chk("rm_memreq", {31'h0, MemReq}, 32'h0);
    chk("rm_mfc",    {31'h0, MFC},    32'h0);
    chk("rm_mbr",    DataOut,         32'h0);
    chk("rm_addr",   MemAddr,         32'h0);
    tick();
    Reset = 1'b0;
    load_mar(32'h40);
    MFA = 1'b1; MemRData = 32'hCAFEF00D;
    tick();
    chk("rr_addr", MemAddr, 32'h40);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    chk("rr_mfc", {31'h0, MFC}, 32'h1);
    chk("rr_mbr", DataOut,      32'hCAFEF00D);
    MFA = 1'b0;
    tick();

    // ---------------- unaligned word read at 0x102 ----------------
    load_mar(32'h102);
    MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b1; MemRData = 32'h55AA55AA;
    tick();                                   // edge 0
`ifdef MIU_ALIGN_CHECK_EN
    chk("ua_memreq", {31'h0, MemReq}, 32'h0);
    chk("ua_mfc",    {31'h0, MFC},    32'h1);
    chk("ua_buserr", {31'h0, BusErr}, 32'h1);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    chk("ua_memreq_late", {31'h0, MemReq}, 32'h0);
    chk("ua_mbr",         DataOut,         32'hCAFEF00D);
`else
    chk("ua_memreq", {31'h0, MemReq}, 32'h1);
    chk("ua_addr",   MemAddr,         32'h100);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    chk("ua_mfc",    {31'h0, MFC},    32'h1);
    chk("ua_buserr", {31'h0, BusErr}, 32'h0);
    chk("ua_mbr",    DataOut,         32'h55AA55AA);
`endif
    MFA = 1'b0;
    tick();
    chk("ua_idle_mfc", {31'h0, MFC}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_interface_unit.md
# memory_interface_unit

Memory interface stage directly downstream of the control unit. It owns the MAR and MBR, turns the control unit's MFA/READ_WRITE/WORD_BYTE request into a req/ack transaction on the memory port, handles byte lanes, and returns MFC once data is latched or written. A timeout guarantees that MFC is always returned, even if memory never answers.

## Interface
- TIMEOUT, default 16: cycles in REQ without MemAck before abort; legal range 1-255.
- Clk  in  1  clock; posedge active.
- Reset  in  1  asynchronous, active-high.
- MARLOAD  in  1  load MAR from DataIn; honoured in IDLE only.
- MBRLOAD  in  1  load MBR from DataIn; honoured in IDLE only.
- MBRSTORE  in  1  drive MBR onto DataOut; otherwise DataOut = 0.
- MFA  in  1  memory function request; level, held until MFC is seen.
- READ_WRITE  in  1  1 = read, 0 = write; sampled with MFA in IDLE.
- WORD_BYTE  in  1  1 = word, 0 = byte; sampled with MFA in IDLE.
- DataIn  in  32  internal bus in.
- DataOut  out  32  internal bus out.
- MFC  out  1  memory function complete.
- BusErr  out  1  valid while MFC = 1; 1 = aborted access.
- MemAddr  out  32  {MAR[31:2], 2'b00}.
- MemWData  out  32  write data.
- MemBE  out  4  byte enables.
- MemReq  out  1  request, held until MemAck or timeout.
- MemWE  out  1  1 = write cycle; valid while MemReq = 1.
- MemAck  in  1  one-cycle acknowledge; read data valid in the same cycle.
- MemRData  in  32  read data.

## Operation
- States:
  - IDLE: on a posedge with MFA = 1, latch op (rd/wr, word/byte), clear timer, go to REQ.
  - REQ: MemReq = 1. MemAck = 1 → go to DONE with BusErr = 0. Timer reaching TIMEOUT → go to DONE with BusErr = 1.
  - DONE: MFC = 1. Stays in DONE while MFA = 1; MFA = 0 → IDLE.
- Word access: MemBE = 4'hF, MemWData = MBR. A read loads MBR = MemRData.
- Byte access: lane k = MAR[1:0], MemBE = 4'b0001 << k.
  - Write: MemWData = {4{MBR[7:0]}}.
  - Read: MBR = {24'h0, MemRData[8k+7:8k]} (zero-extended).
- MemWE = latched READ_WRITE inverted.
- MBR updates only on a read ack. An aborted read leaves MBR unchanged.
- MemAck outside REQ is ignored.
- MARLOAD/MBRLOAD outside IDLE are ignored. If either is asserted in the same IDLE cycle as MFA, the load happens and the transaction uses the old MAR/MBR value.
- DataOut is combinational: MBRSTORE ? MBR : 0.

## Timing
- Reset values: state IDLE; MAR = MBR = 0; all outputs 0. Asserting Reset mid-transaction drops MemReq and MFC immediately.
- Zero-wait memory: MFA sampled at edge 0 → MemReq high after edge 0 → MemAck at edge 1 → MFC high after edge 1. MFA-to-MFC latency is 2 edges.
- Each memory wait cycle adds one cycle of latency.
- Abort: MemReq is held for exactly TIMEOUT cycles, then MFC = 1 and BusErr = 1.
- MFC falls the cycle after MFA is seen low. A new MFA is accepted no earlier than the following edge, so there is at least one IDLE cycle between transactions.
- MemAck on the same edge the timer expires: the ack wins, BusErr = 0.

## Configuration
- MIU_ALIGN_CHECK_EN defined:
  - A word access with MAR[1:0] ≠ 0 goes IDLE → DONE directly.
  - No MemReq is issued; MFC = 1 and BusErr = 1 one edge after MFA is sampled.
  - MBR is unchanged.
- Not defined: MAR[1:0] is ignored for word accesses and the access proceeds normally.

## Test plan
- Word read, zero wait: MAR = 0x100, MemRData = 0xDEADBEEF, ack on the first REQ cycle → MemAddr = 0x100, BE = F, MFC after 2 edges, MBR = 0xDEADBEEF, BusErr = 0.
- Byte write with 3 wait cycles: MAR = 0x203, MBR = 0x000000A5 → MemBE = 1000, MemWData = 0xA5A5A5A5, MemWE = 1, MFC after 5 edges.
- Byte read: MAR = 0x11, MemRData = 0x44332211 → MBR = 0x00000022.
- Timeout with TIMEOUT = 4 and no ack: MemReq high for exactly 4 cycles, then MFC = 1, BusErr = 1, MBR unchanged. Drop MFA → IDLE next edge.
- Reset asserted mid-REQ: MemReq = MFC = 0 immediately, MAR = MBR = 0. After release, a new read completes normally.
- MIU_ALIGN_CHECK_EN, word read at MAR = 0x102: MemReq never asserts; MFC = 1 and BusErr = 1 one edge after MFA.
